// File: rtl/two_to_four_decoder_pkg.sv
// Shared types and decode helper for the 2-to-4 line decoder.
package two_to_four_decoder_pkg;

  localparam int unsigned SEL_W   = 2;
  localparam int unsigned NUM_OUT = 4;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [NUM_OUT-1:0] onehot_t;

  // Active-high one-hot image of a select value.
  function automatic onehot_t decode_onehot(input sel_t sel);
    onehot_t r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/two_to_four_decoder_core.sv
// Purely combinational enable-gated decode: {en,a,b} -> active-high one-hot.
module dec2to4_core
  import two_to_four_decoder_pkg::*;
(
  input  logic    en,
  input  logic    a,
  input  logic    b,
  output onehot_t onehot
);

  // All lines low when disabled, otherwise exactly one line high.
  always_comb begin
    onehot = '0;
    if (en) onehot = decode_onehot({a, b});
  end

endmodule

// File: rtl/two_to_four_decoder.sv
// 2-to-4 decoder with optional output registers, valid flag, change pulse
// and selectable output polarity.
module two_to_four_decoder
  import two_to_four_decoder_pkg::*;
#(
  parameter bit REGISTERED     = 1'b1,
  parameter bit ACTIVE_LOW_OUT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic q0,
  output logic q1,
  output logic q2,
  output logic q3,
  output logic valid,
  output logic chg
);

  sel_t    sel;
  onehot_t dec;
  onehot_t hot;
  onehot_t out_lines;
  logic    valid_int;
  logic    chg_int;

  assign sel = {a, b};

  dec2to4_core u_core (
    .en     (en),
    .a      (a),
    .b      (b),
    .onehot (dec)
  );

  generate
    if (REGISTERED) begin : g_reg
      onehot_t hot_q;
      logic    valid_q;
      logic    chg_q;
      sel_t    prev_idx;

      // Register decode, valid and change pulse; the valid register doubles
      // as "previous cycle was valid" for the change comparison.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hot_q    <= '0;
          valid_q  <= 1'b0;
          chg_q    <= 1'b0;
          prev_idx <= '0;
        end else begin
          hot_q   <= dec;
          valid_q <= en;
          chg_q   <= en & (~valid_q | (sel != prev_idx));
          if (en) prev_idx <= sel;
        end
      end

      assign hot       = hot_q;
      assign valid_int = valid_q;
      assign chg_int   = chg_q;
    end else begin : g_comb
      logic prev_valid;
      sel_t prev_idx;

      // Track the last cycle's validity and last valid index for chg.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_valid <= 1'b0;
          prev_idx   <= '0;
        end else begin
          prev_valid <= en;
          if (en) prev_idx <= sel;
        end
      end

      // Reset gates the combinational path so no partial decode escapes.
      assign valid_int = en & rst_n;
      assign hot       = rst_n ? dec : '0;
      assign chg_int   = valid_int & (~prev_valid | (sel != prev_idx));
    end
  endgenerate

  assign out_lines = ACTIVE_LOW_OUT ? ~hot : hot;

  assign q0    = out_lines[0];
  assign q1    = out_lines[1];
  assign q2    = out_lines[2];
  assign q3    = out_lines[3];
  assign valid = valid_int;
  assign chg   = chg_int;

endmodule

// File: tb/tb_two_to_four_decoder.sv
// Directed and randomized checks of registered, active-low and
// combinational decoder variants driven from shared stimulus.
module tb_two_to_four_decoder;

  logic clk = 1'b0;
  logic rst_n, en, a, b;

  logic q0_r, q1_r, q2_r, q3_r, valid_r, chg_r;
  logic q0_l, q1_l, q2_l, q3_l, valid_l, chg_l;
  logic q0_c, q1_c, q2_c, q3_c, valid_c, chg_c;

  logic [3:0] qr, ql, qc;
  assign qr = {q3_r, q2_r, q1_r, q0_r};
  assign ql = {q3_l, q2_l, q1_l, q0_l};
  assign qc = {q3_c, q2_c, q1_c, q0_c};

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  two_to_four_decoder #(.REGISTERED(1'b1), .ACTIVE_LOW_OUT(1'b0)) u_reg (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
    .q0(q0_r), .q1(q1_r), .q2(q2_r), .q3(q3_r), .valid(valid_r), .chg(chg_r)
  );

  two_to_four_decoder #(.REGISTERED(1'b1), .ACTIVE_LOW_OUT(1'b1)) u_low (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
    .q0(q0_l), .q1(q1_l), .q2(q2_l), .q3(q3_l), .valid(valid_l), .chg(chg_l)
  );

  two_to_four_decoder #(.REGISTERED(1'b0), .ACTIVE_LOW_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
    .q0(q0_c), .q1(q1_c), .q2(q2_c), .q3(q3_c), .valid(valid_c), .chg(chg_c)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic       m_prev_valid;
  logic [1:0] m_prev_idx;
  logic [3:0] m_q;
  logic       m_chg;

  initial begin
    rst_n = 1'b0; en = 1'b1; a = 1'b1; b = 1'b1;
    step();
    step();
    check("rst_q",        qr,      4'b0000);
    check("rst_valid",    valid_r, 1'b0);
    check("rst_chg",      chg_r,   1'b0);
    check("rst_q_low",    ql,      4'b1111);
    check("rst_q_comb",   qc,      4'b0000);
    check("rst_val_comb", valid_c, 1'b0);
    check("rst_chg_comb", chg_c,   1'b0);

    rst_n = 1'b1;
    {a, b} = 2'b00; step();
    check("dec00_q", qr, 4'b0001); check("dec00_v", valid_r, 1'b1); check("dec00_c", chg_r, 1'b1);
    {a, b} = 2'b01; step();
    check("dec01_q", qr, 4'b0010); check("dec01_v", valid_r, 1'b1); check("dec01_c", chg_r, 1'b1);
    {a, b} = 2'b10; step();
    check("dec10_q", qr, 4'b0100); check("dec10_v", valid_r, 1'b1); check("dec10_c", chg_r, 1'b1);
    {a, b} = 2'b11; step();
    check("dec11_q", qr, 4'b1000); check("dec11_v", valid_r, 1'b1); check("dec11_c", chg_r, 1'b1);

    {a, b} = 2'b10; step();
    check("hold1_q", qr, 4'b0100); check("hold1_c", chg_r, 1'b1);
    step();
    check("hold2_q", qr, 4'b0100); check("hold2_c", chg_r, 1'b0);
    step();
    check("hold3_q", qr, 4'b0100); check("hold3_c", chg_r, 1'b0);

    en = 1'b0; step();
    check("dis_q", qr, 4'b0000); check("dis_v", valid_r, 1'b0); check("dis_c", chg_r, 1'b0);
    check("dis_q_low", ql, 4'b1111);

    en = 1'b1; step();
    check("reen_q", qr, 4'b0100); check("reen_v", valid_r, 1'b1); check("reen_c", chg_r, 1'b1);

    {a, b} = 2'b01; step();
    check("low01_q", ql, 4'b1101); check("low01_v", valid_l, 1'b1); check("low01_c", chg_l, 1'b1);

    {a, b} = 2'b00; step();
    check("comb00_q", qc, 4'b0001);
    #2 {a, b} = 2'b11;
    #1;
    check("comb11_q",    qc,      4'b1000);
    check("comb11_v",    valid_c, 1'b1);
    check("comb11_c",    chg_c,   1'b1);
    check("comb_reg_hold", qr,    4'b0001);
    step();
    check("comb11_c_after", chg_c, 1'b0);
    check("comb11_q_after", qc,    4'b1000);
    check("reg11_q",        qr,    4'b1000);

    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_q",      qr,      4'b0000);
    check("mid_rst_v",      valid_r, 1'b0);
    check("mid_rst_c",      chg_r,   1'b0);
    check("mid_rst_q_low",  ql,      4'b1111);
    check("mid_rst_q_comb", qc,      4'b0000);
    check("mid_rst_v_comb", valid_c, 1'b0);
    step();
    rst_n = 1'b1;

    m_prev_valid = 1'b0;
    m_prev_idx   = 2'b00;
    for (int i = 0; i < 1000; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
      a  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      step();
      m_q   = en ? (4'b0001 << {a, b}) : 4'b0000;
      m_chg = en & (~m_prev_valid | ({a, b} != m_prev_idx));
      check("rnd_q",     qr,      m_q);
      check("rnd_v",     valid_r, en);
      check("rnd_c",     chg_r,   m_chg);
      check("rnd_pop",   4'($countones(qr)), valid_r ? 4'd1 : 4'd0);
      check("rnd_low",   ql,      ~qr);
      check("rnd_pop_c", 4'($countones(qc)), valid_c ? 4'd1 : 4'd0);
      m_prev_valid = en;
      if (en) m_prev_idx = {a, b};
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
